upe_negate_serial: RTL
======================

UPE_NEGATE_SERIAL -- requirements
Module: upe_negate_serial

Interface
REQ-001 Parameter WIDTH, default 64: operand/result width in bits; SHALL be a multiple of DIGIT and >= 2.
REQ-002 Parameter DIGIT, default 1: bits processed per clock in RUN; SHALL divide WIDTH.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand offered.
REQ-006 in_ready  output  1  block accepts an operand this cycle.
REQ-007 in_data  input  WIDTH  two's-complement operand.
REQ-008 in_mode  input  2  operation: 00 pass, 01 negate, 10 absolute value, 11 reserved (treated as pass).
REQ-009 out_valid  output  1  result held and valid.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 out_data  output  WIDTH  result.
REQ-012 out_ovf  output  1  result not representable: negate or abs of the most-negative value.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DONE, with in_ready = (state == IDLE) and out_valid = (state == DONE).
REQ-014 IDLE: in_valid & in_ready SHALL latch in_data and in_mode, clear the digit counter, set carry to 1, and go to RUN.
REQ-015 In RUN, each cycle SHALL process DIGIT bits LSB-first: negate computes ~x + carry per slice, pass copies the bits, and abs negates only when latched in_data[WIDTH-1] = 1.
REQ-016 RUN SHALL last exactly WIDTH/DIGIT cycles, then go to DONE.
REQ-017 Latency: with operand accepted at edge k, out_valid SHALL be 1 after edge k + WIDTH/DIGIT.
REQ-018 DONE SHALL hold out_data and out_ovf stable until out_valid & out_ready, then go to IDLE, so in_ready = 1 in the following cycle.
REQ-019 Throughput: at most one operand per WIDTH/DIGIT + 2 cycles; in_valid while not IDLE SHALL be ignored.
REQ-020 out_ovf SHALL be 1 iff the mode is negate or abs and the operand equals 1 followed by WIDTH-1 zeros; out_data then SHALL equal the operand (wrap-around).
REQ-021 Negate of 0 SHALL give 0 with out_ovf = 0, with the final carry discarded.
REQ-022 Pass mode SHALL give out_ovf = 0.
REQ-023 Changes on in_data or in_mode after acceptance SHALL NOT affect the in-flight result.

Reset
REQ-024 reset = 1 at a clock edge SHALL force IDLE with out_data = 0, out_ovf = 0, out_valid = 0, in_ready = 1 on the next cycle, and the counter and carry cleared.
REQ-025 Reset mid-RUN or in DONE SHALL discard the operation, with no out_valid pulse produced.
REQ-026 Reset SHALL take priority over simultaneous in_valid and out_ready.

Structure
REQ-027 Shared package upe_pkg SHALL hold the mode encodings (UPE_MODE_PASS, UPE_MODE_NEG, UPE_MODE_ABS) and the FSM state type.
REQ-028 Sub-module upe_negate_digit SHALL provide the combinational DIGIT-bit slice (inputs: bits, carry_in, invert; outputs: bits, carry_out), instantiated once.
REQ-029 The operand SHALL be held in one WIDTH-bit shift register that shifts right by DIGIT per RUN cycle, with result digits entering at the MSB end, so out_data is the same register.

Verification
REQ-030 WIDTH=64, DIGIT=1, negate 64'hA32AEACECB2AEACE -> out_data 64'h5CD5153134D51532, out_ovf 0, out_valid 64 cycles after acceptance.
REQ-031 WIDTH=64, DIGIT=4, negate 64'h8000000000000000 -> out_data 64'h8000000000000000, out_ovf 1, latency 16 cycles; then negate 0 -> 0, out_ovf 0.
REQ-032 WIDTH=8, DIGIT=2, abs of 8'hFB -> 8'h05, and abs of 8'h05 -> 8'h05; pass of 8'h80 -> 8'h80, out_ovf 0.
REQ-033 Backpressure: hold out_ready = 0 for 10 cycles in DONE -> out_data and out_valid stable, in_ready 0, and a new in_valid pulse is ignored; the out_ready pulse gives in_ready = 1 next cycle.
REQ-034 Assert reset at RUN cycle 3 of a 64-bit negate -> in_ready 1 and out_valid 0 next cycle, and a subsequent negate of 64'h1 -> 64'hFFFFFFFFFFFFFFFF.
REQ-035 Back-to-back: in_valid held high with 3 operands -> 3 results in order, each on its own out_valid/out_ready handshake.

Source files
------------

// File: rtl/upe_pkg.sv
// Shared encodings for the unit-processing-element blocks: operation modes and
// the serial FSM state type.
package upe_pkg;

    typedef logic [1:0] upe_mode_t;

    localparam upe_mode_t UPE_MODE_PASS = 2'b00;
    localparam upe_mode_t UPE_MODE_NEG  = 2'b01;
    localparam upe_mode_t UPE_MODE_ABS  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } upe_state_e;

endpackage

// File: rtl/upe_negate_serial_if.sv
// Operand/result handshake bundle for upe_negate_serial; the slave modport is the
// block side, the master modport is the producer/consumer side.
interface upe_negate_serial_if #(
    parameter int WIDTH = 64
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    upe_pkg::upe_mode_t   in_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic                 out_ovf;

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/upe_negate_digit.sv
// One DIGIT-bit slice of the serial two's-complement negator: ~x + carry when
// invert is set, straight copy (carry out 0) otherwise.
module upe_negate_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] bits_i,
    input  logic             carry_i,
    input  logic             invert_i,
    output logic [DIGIT-1:0] bits_o,
    output logic             carry_o
);
    logic [DIGIT-1:0] x;
    logic [DIGIT:0]   sum;

    assign x       = bits_i ^ {DIGIT{invert_i}};
    assign sum     = {1'b0, x} + {{DIGIT{1'b0}}, carry_i & invert_i};
    assign bits_o  = sum[DIGIT-1:0];
    assign carry_o = sum[DIGIT];
endmodule

// File: rtl/upe_negate_serial.sv
// Digit-serial pass / negate / abs unit: the operand sits in one shift register,
// result digits re-enter at the MSB end, and that register is the result.
module upe_negate_serial
    import upe_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DIGIT = 1
) (
    input  logic clk,
    input  logic reset,
    upe_negate_serial_if.slave bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = $clog2(NDIG + 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    upe_state_e       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             inv_q, inv_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT-1:0] dig_bits;
    logic             dig_carry;
    logic [WIDTH-1:0] shifted;

    upe_negate_digit #(.DIGIT(DIGIT)) u_digit (
        .bits_i   (data_q[DIGIT-1:0]),
        .carry_i  (carry_q),
        .invert_i (inv_q),
        .bits_o   (dig_bits),
        .carry_o  (dig_carry)
    );

    generate
        if (DIGIT == WIDTH) begin : g_single
            assign shifted = dig_bits;
        end else begin : g_shift
            assign shifted = {dig_bits, data_q[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            inv_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            inv_q   <= inv_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        inv_d   = inv_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    data_d  = bus.in_data;
                    cnt_d   = '0;
                    carry_d = 1'b1;
                    // Mode is reduced to a single invert decision at acceptance.
                    inv_d   = (bus.in_mode == UPE_MODE_NEG) ||
                              ((bus.in_mode == UPE_MODE_ABS) && bus.in_data[WIDTH-1]);
                    ovf_d   = ((bus.in_mode == UPE_MODE_NEG) || (bus.in_mode == UPE_MODE_ABS)) &&
                              (bus.in_data == MOST_NEG);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                data_d  = shifted;
                carry_d = dig_carry;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(NDIG - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out_data  = data_q;
    assign bus.out_ovf   = ovf_q;
endmodule
